// File: rtl/logic_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : logic_unit_pkg
//  Purpose  : Shared types for the logic unit pipeline: operation encoding,
//             FSM state encoding and the reduction-op classifier.
//  Revision : 1.0  initial release
// ============================================================================
package logic_unit_pkg;

    typedef enum logic [2:0] {
        OP_AND    = 3'd0,
        OP_OR     = 3'd1,
        OP_XOR    = 3'd2,
        OP_NOR    = 3'd3,
        OP_XNOR   = 3'd4,
        OP_ANDN   = 3'd5,
        OP_POPCNT = 3'd6,
        OP_PARITY = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Reduction ops run multi-cycle over a^b; everything else is one cycle.
    function automatic logic is_reduction(input op_e op);
        return (op == OP_POPCNT) || (op == OP_PARITY);
    endfunction

endpackage
`default_nettype wire

// File: rtl/logic_unit_pipe_popcount_chunk.sv
`default_nettype none
// ============================================================================
//  Module   : popcount_chunk
//  Purpose  : Combinational population count of one CHUNK-bit slice.
//  Ports    : bits  [CHUNK-1:0] in   slice to count
//             count [CW-1:0]    out  number of set bits
//  Revision : 1.0  initial release
// ============================================================================
module popcount_chunk #(
    parameter int CHUNK = 8,
    parameter int CW    = $clog2(CHUNK + 1)
) (
    input  logic [CHUNK-1:0] bits,
    output logic [CW-1:0]    count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < CHUNK; i++) begin
            count = count + CW'(bits[i]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : logic_unit_pipe
//  Purpose  : Handshaked bitwise logic unit. Ops 0-5 complete in one cycle;
//             POPCNT/PARITY of a^b are reduced CHUNK bits per cycle.
//  Ports    : clk, rst_n (sync, active-low)
//             in_valid/in_ready, op[2:0], a, b   request side
//             out_valid/out_ready, result, zero  response side
//  Revision : 1.0  initial release
// ============================================================================
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int c_nch   = WIDTH / CHUNK;
    localparam int c_acc_w = $clog2(WIDTH + 1);
    localparam int c_pc_w  = $clog2(CHUNK + 1);
    localparam int c_cnt_w = (c_nch > 1) ? $clog2(c_nch) : 1;
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(c_nch - 1);

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("logic_unit_pipe: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_e             r_state;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic [WIDTH-1:0]   r_x;
    logic [c_acc_w-1:0] r_acc;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_parity;

    op_e                w_op;
    logic               w_ready;
    logic               w_accept;
    logic [WIDTH-1:0]   w_bitwise;
    logic [c_pc_w-1:0]  w_chunk_cnt;
    logic [c_acc_w-1:0] w_acc_sum;
    logic [WIDTH-1:0]   w_red_result;

    assign w_op = op_e'(op);

    // HOLD lets a new request in on the same edge the result is consumed.
    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            ST_IDLE: w_ready = 1'b1;
            ST_HOLD: w_ready = out_ready;
            default: w_ready = 1'b0;
        endcase
    end

    assign in_ready = rst_n & w_ready;
    assign w_accept = in_valid & in_ready;

    always_comb begin
        w_bitwise = '0;
        case (w_op)
            OP_AND:  w_bitwise = a & b;
            OP_OR:   w_bitwise = a | b;
            OP_XOR:  w_bitwise = a ^ b;
            OP_NOR:  w_bitwise = ~(a | b);
            OP_XNOR: w_bitwise = ~(a ^ b);
            OP_ANDN: w_bitwise = a & ~b;
            default: w_bitwise = '0;
        endcase
    end

    popcount_chunk #(
        .CHUNK (CHUNK),
        .CW    (c_pc_w)
    ) u_popcount_chunk (
        .bits  (r_x[CHUNK-1:0]),
        .count (w_chunk_cnt)
    );

    // Sum including the current chunk; on the last BUSY edge this is final.
    assign w_acc_sum    = r_acc + c_acc_w'(w_chunk_cnt);
    assign w_red_result = r_parity ? WIDTH'(w_acc_sum[0]) : WIDTH'(w_acc_sum);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_x         <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_parity    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_HOLD: begin
                    if (r_state == ST_HOLD && out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                    end
                    // An accept overrides the drop to IDLE above.
                    if (w_accept) begin
                        if (is_reduction(w_op)) begin
                            r_x         <= a ^ b;
                            r_acc       <= '0;
                            r_cnt       <= '0;
                            r_parity    <= (w_op == OP_PARITY);
                            r_state     <= ST_BUSY;
                            r_out_valid <= 1'b0;
                        end else begin
                            r_result    <= w_bitwise;
                            r_zero      <= (w_bitwise == '0);
                            r_state     <= ST_HOLD;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                ST_BUSY: begin
                    r_acc <= w_acc_sum;
                    r_x   <= r_x >> CHUNK;
                    r_cnt <= r_cnt + c_cnt_w'(1);
                    if (r_cnt == c_last_cnt) begin
                        r_result    <= w_red_result;
                        r_zero      <= (w_red_result == '0);
                        r_state     <= ST_HOLD;
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_logic_unit_pipe
//  Purpose  : Directed self-checking bench for logic_unit_pipe (32/8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_logic_unit_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    int n_pass;
    int n_total;

    logic_unit_pipe #(.WIDTH(32), .CHUNK(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = 3'd0; a = '0; b = '0;
        step(); step();
        n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b want=0", out_valid); else n_pass++;
        n_total++; if (result !== 32'h0) $display("FAIL rst_result got=%h want=0", result); else n_pass++;
        n_total++; if (zero !== 1'b0) $display("FAIL rst_zero got=%b want=0", zero); else n_pass++;
        n_total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready_low got=%b want=0", in_ready); else n_pass++;
        rst_n = 1'b1; #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready_release got=%b want=1", in_ready); else n_pass++;
    endtask

    task automatic test_xor();
        in_valid = 1'b1; op = 3'd2; a = 32'hF0F0_1234; b = 32'h0FF0_1234; out_ready = 1'b1;
        step();
        n_total++; if (out_valid !== 1'b1) $display("FAIL xor_valid got=%b want=1", out_valid); else n_pass++;
        n_total++; if (result !== 32'hFF00_0000) $display("FAIL xor_result got=%h want=ff000000", result); else n_pass++;
        n_total++; if (zero !== 1'b0) $display("FAIL xor_zero got=%b want=0", zero); else n_pass++;
        a = 32'hDEAD_BEEF; b = 32'hDEAD_BEEF;
        step();
        n_total++; if (result !== 32'h0) $display("FAIL xor_eq_result got=%h want=0", result); else n_pass++;
        n_total++; if (zero !== 1'b1) $display("FAIL xor_eq_zero got=%b want=1", zero); else n_pass++;
        in_valid = 1'b0;
        step();
        n_total++; if (out_valid !== 1'b0) $display("FAIL xor_drain got=%b want=0", out_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; out_ready = 1'b1; op = 3'd3; a = 32'h0; b = 32'h0;
        step();
        n_total++; if (result !== 32'hFFFF_FFFF) $display("FAIL b2b_nor got=%h want=ffffffff", result); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL b2b_ready got=%b want=1", in_ready); else n_pass++;
        op = 3'd5; a = 32'hFFFF_FFFF; b = 32'h0000_FFFF;
        step();
        n_total++; if (result !== 32'hFFFF_0000) $display("FAIL b2b_andn got=%h want=ffff0000", result); else n_pass++;
        n_total++; if (out_valid !== 1'b1) $display("FAIL b2b_valid got=%b want=1", out_valid); else n_pass++;
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_popcnt();
        in_valid = 1'b1; out_ready = 1'b1; op = 3'd6; a = 32'hFFFF_FFFF; b = 32'h0;
        step();
        in_valid = 1'b0; a = 32'h0;
        for (int i = 0; i < 4; i++) begin
            n_total++; if (in_ready !== 1'b0 || out_valid !== 1'b0)
                $display("FAIL popcnt_busy%0d in_ready=%b out_valid=%b want 0/0", i, in_ready, out_valid);
            else n_pass++;
            step();
        end
        n_total++; if (out_valid !== 1'b1) $display("FAIL popcnt_valid got=%b want=1", out_valid); else n_pass++;
        n_total++; if (result !== 32'h20) $display("FAIL popcnt_result got=%h want=20", result); else n_pass++;
        step();
        n_total++; if (out_valid !== 1'b0) $display("FAIL popcnt_drain got=%b want=0", out_valid); else n_pass++;
    endtask

    task automatic test_parity();
        in_valid = 1'b1; out_ready = 1'b1; op = 3'd7; a = 32'h7; b = 32'h0;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        n_total++; if (result !== 32'h1) $display("FAIL parity_odd got=%h want=1", result); else n_pass++;
        n_total++; if (zero !== 1'b0) $display("FAIL parity_odd_zero got=%b want=0", zero); else n_pass++;
        in_valid = 1'b1; a = 32'h3;
        step();
        n_total++; if (out_valid !== 1'b0) $display("FAIL parity_reaccept got=%b want=0", out_valid); else n_pass++;
        in_valid = 1'b0;
        repeat (4) step();
        n_total++; if (out_valid !== 1'b1) $display("FAIL parity_even_valid got=%b want=1", out_valid); else n_pass++;
        n_total++; if (result !== 32'h0) $display("FAIL parity_even got=%h want=0", result); else n_pass++;
        n_total++; if (zero !== 1'b1) $display("FAIL parity_even_zero got=%b want=1", zero); else n_pass++;
        step();
    endtask

    task automatic test_hold_stall();
        in_valid = 1'b1; out_ready = 1'b0; op = 3'd5; a = 32'hAAAA_5555; b = 32'h0000_FFFF;
        step();
        in_valid = 1'b0; a = 32'h0; b = 32'h0;
        for (int i = 0; i < 3; i++) begin
            n_total++; if (result !== 32'hAAAA_0000 || out_valid !== 1'b1 || in_ready !== 1'b0)
                $display("FAIL stall%0d result=%h valid=%b ready=%b want aaaa0000/1/0", i, result, out_valid, in_ready);
            else n_pass++;
            step();
        end
        out_ready = 1'b1; in_valid = 1'b1; op = 3'd6; a = 32'h0000_000F; b = 32'h0; #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL stall_release_ready got=%b want=1", in_ready); else n_pass++;
        step();
        in_valid = 1'b0;
        n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL stall_to_busy valid=%b ready=%b want 0/0", out_valid, in_ready);
        else n_pass++;
        repeat (4) step();
        n_total++; if (result !== 32'h4) $display("FAIL stall_popcnt got=%h want=4", result); else n_pass++;
        step();
    endtask

    task automatic test_reset_mid_busy();
        in_valid = 1'b1; out_ready = 1'b1; op = 3'd6; a = 32'hFFFF_FFFF; b = 32'h0;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        n_total++; if (out_valid !== 1'b0) $display("FAIL midrst_valid got=%b want=0", out_valid); else n_pass++;
        n_total++; if (result !== 32'h0) $display("FAIL midrst_result got=%h want=0", result); else n_pass++;
        rst_n = 1'b1; #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL midrst_ready got=%b want=1", in_ready); else n_pass++;
        repeat (5) step();
        n_total++; if (out_valid !== 1'b0) $display("FAIL midrst_no_stale got=%b want=0", out_valid); else n_pass++;
        in_valid = 1'b1; op = 3'd2; a = 32'h1234_5678; b = 32'hFFFF_0000;
        step();
        in_valid = 1'b0;
        n_total++; if (out_valid !== 1'b1 || result !== 32'hEDCB_5678)
            $display("FAIL midrst_xor valid=%b result=%h want 1/edcb5678", out_valid, result);
        else n_pass++;
        step();
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 3'd0; a = '0; b = '0;
        test_reset();
        test_xor();
        test_back_to_back();
        test_popcnt();
        test_parity();
        test_hold_stall();
        test_reset_mid_busy();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
